line_mem_responder: RTL and testbench

- Synthesizable responder for the 128-bit line memory interface driven by the mp3 core: accepts line read/write requests on read/write/address/wdata and answers with a single-cycle resp.
- Backed by an internal line array. Fixed, parameterizable access latency models DRAM delay.
- Replaces the behavioural memory in FPGA builds. Drops in on the same port names as the core's mem_* bus.

---
 rtl/line_mem_responder.sv | 158 +++++++++++++++
 tb/tb_line_mem_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder
// ------------------
// Line-granular memory responder for the 128-bit line bus of the mp3 core.
// Takes one read or write request at a time and completes it after a fixed
// latency that models DRAM delay. Storage is an internal array of 2^IDX_W
// lines. The array is not reset, so its contents survive a reset.
//
// Ports
//   clk          : clock; all state changes on the rising edge
//   rst_n        : asynchronous active-low reset
//   read         : read request, held by the initiator until resp
//   write        : write request, held by the initiator until resp
//   address      : byte address; the low four bits select a byte in the line
//                  and are ignored
//   wdata        : write line, held together with write
//   resp         : one-cycle completion pulse
//   rdata        : line returned by the most recent completed read
//   protocol_err : sticky flag for initiator protocol violations
//   rd_count     : number of completed reads, wraps at 16 bits
//   wr_count     : number of completed writes, wraps at 16 bits
module line_mem_responder #(
    parameter int ADDR_W    = 16,
    parameter int LINE_W    = 128,
    parameter int IDX_W     = 6,
    parameter int READ_LAT  = 8,
    parameter int WRITE_LAT = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [LINE_W-1:0] wdata,
    output logic              resp,
    output logic [LINE_W-1:0] rdata,
    output logic              protocol_err,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int DEPTH = 2 ** IDX_W;

    // Acceptance happens in cycle 0 and resp is visible in cycle LAT, so the
    // BUSY phase lasts LAT-1 cycles. The counter therefore starts at LAT-2
    // and BUSY exits on the cycle it reads zero.
    localparam logic [15:0] READ_LOAD  = 16'(READ_LAT - 2);
    localparam logic [15:0] WRITE_LOAD = 16'(WRITE_LAT - 2);

    state_t              state;
    state_t              state_next;
    logic [15:0]         cnt;
    logic                op_rd;
    logic [IDX_W-1:0]    idx;
    logic [ADDR_W-5:0]   line_addr;
    logic [LINE_W-1:0]   wbuf;
    logic                read_d;
    logic                write_d;
    logic [LINE_W-1:0]   mem [DEPTH];

    logic accept;
    logic done;
    logic busy_violation;

    assign accept = (state == IDLE) && (read || write);
    assign done   = (state == BUSY) && (cnt == 16'd0);
    assign resp   = (state == RESP);

    // While BUSY the initiator must keep its request and address steady.
    // A rising edge on the opposite request is flagged; a request that was
    // already high at acceptance (read+write collision) is not counted twice.
    always_comb begin
        busy_violation = 1'b0;
        if (state == BUSY) begin
            if (op_rd) begin
                busy_violation = !read || (write && !write_d);
            end else begin
                busy_violation = !write || (read && !read_d);
            end
            if (address[ADDR_W-1:4] != line_addr) begin
                busy_violation = 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (read || write) state_next = BUSY;
            BUSY:    if (cnt == 16'd0) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control, counters and the read-return register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 16'd0;
            rdata        <= '0;
            protocol_err <= 1'b0;
            rd_count     <= 16'd0;
            wr_count     <= 16'd0;
        end else begin
            state <= state_next;

            if (accept) begin
                // Collision of read and write is serviced as a write.
                cnt <= (read && !write) ? READ_LOAD : WRITE_LOAD;
            end else if (state == BUSY && cnt != 16'd0) begin
                cnt <= cnt - 16'd1;
            end

            if ((accept && read && write) || busy_violation) begin
                protocol_err <= 1'b1;
            end

            if (done && op_rd) begin
                rdata <= mem[idx];
            end

            if (state == RESP) begin
                if (op_rd) begin
                    rd_count <= rd_count + 16'd1;
                end else begin
                    wr_count <= wr_count + 16'd1;
                end
            end
        end
    end

    // Request capture; these are only meaningful while an op is in flight.
    always_ff @(posedge clk) begin
        read_d  <= read;
        write_d <= write;
        if (accept) begin
            op_rd     <= read && !write;
            idx       <= address[4+IDX_W-1:4];
            line_addr <= address[ADDR_W-1:4];
            wbuf      <= wdata;
        end
    end

    // Array update on entry to RESP. A reset forces state to IDLE at once,
    // so a write that has not reached this edge is dropped.
    always_ff @(posedge clk) begin
        if (done && !op_rd) begin
            mem[idx] <= wbuf;
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
// Testbench for line_mem_responder: directed scenarios plus randomized
// traffic, scored against a line-array reference model.
module tb_line_mem_responder;

    localparam int ADDR_W    = 16;
    localparam int LINE_W    = 128;
    localparam int IDX_W     = 6;
    localparam int READ_LAT  = 8;
    localparam int WRITE_LAT = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [ADDR_W-1:0] address = '0;
    logic [LINE_W-1:0] wdata = '0;
    logic              resp;
    logic [LINE_W-1:0] rdata;
    logic              protocol_err;
    logic [15:0]       rd_count;
    logic [15:0]       wr_count;

    line_mem_responder #(
        .ADDR_W(ADDR_W), .LINE_W(LINE_W), .IDX_W(IDX_W),
        .READ_LAT(READ_LAT), .WRITE_LAT(WRITE_LAT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .read(read), .write(write),
        .address(address), .wdata(wdata), .resp(resp), .rdata(rdata),
        .protocol_err(protocol_err), .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit                is_rd;
        logic [LINE_W-1:0] data;
        int                due;
    } exp_t;

    exp_t              exp_q[$];
    logic [LINE_W-1:0] model_mem [int];
    int                checks = 0;
    int                failures = 0;
    bit                exp_err = 1'b0;
    logic [15:0]       exp_rd = 16'd0;
    logic [15:0]       exp_wr = 16'd0;
    int                last_resp = -10;

    task automatic check(input string name, input logic [LINE_W-1:0] act,
                         input logic [LINE_W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Monitor: every resp pulse must match the oldest outstanding op.
    always @(negedge clk) begin
        if (resp === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp at cycle %0d actual=1 required=0", cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("resp_cycle", LINE_W'(cyc), LINE_W'(e.due));
                if (e.is_rd) check("rdata", rdata, e.data);
            end
        end
    end

    // Issues one op from a negedge and returns at the negedge of its resp.
    // glitch: 0 none, 1 drop the request 3 cycles in, 2 move the address.
    task automatic do_op(input bit is_rd, input bit both,
                         input logic [ADDR_W-1:0] addr,
                         input logic [LINE_W-1:0] wd, input int glitch);
        int   lat;
        int   idx;
        int   n;
        int   acc;
        exp_t e;
        idx = int'(addr[4+IDX_W-1:4]);
        lat = is_rd ? READ_LAT : WRITE_LAT;
        // If the DUT is in its resp cycle, acceptance is the following cycle.
        acc = (cyc == last_resp) ? cyc + 1 : cyc;
        read    = is_rd | both;
        write   = !is_rd;
        address = addr;
        wdata   = wd;
        e.is_rd = is_rd;
        e.due   = acc + lat;
        if (is_rd) begin
            e.data = model_mem.exists(idx) ? model_mem[idx] : 'x;
        end else begin
            e.data = wd;
            model_mem[idx] = wd;
        end
        if (both) exp_err = 1'b1;
        exp_q.push_back(e);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (cyc == acc + 1) check("protocol_err_early", LINE_W'(protocol_err), LINE_W'(exp_err));
            if (cyc == acc + 3 && glitch == 1) begin
                read  = 1'b0;
                write = 1'b0;
            end
            if (cyc == acc + 3 && glitch == 2) address = addr ^ 16'h0010;
        end while (resp !== 1'b1 && n < lat + 6);
        if (glitch != 0) exp_err = 1'b1;
        if (resp !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout addr=%h actual=no_resp required=resp", addr);
        end
        last_resp = cyc;
        if (is_rd) exp_rd = exp_rd + 16'd1;
        else       exp_wr = exp_wr + 16'd1;
    endtask

    task automatic idle(input int n);
        read  = 1'b0;
        write = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        read  = 1'b0;
        write = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        exp_err   = 1'b0;
        exp_rd    = 16'd0;
        exp_wr    = 16'd0;
        last_resp = -10;
    endtask

    task automatic check_counts();
        check("rd_count", LINE_W'(rd_count), LINE_W'(exp_rd));
        check("wr_count", LINE_W'(wr_count), LINE_W'(exp_wr));
    endtask

    initial begin
        logic [LINE_W-1:0] pat_a;
        logic [LINE_W-1:0] pat_b;
        logic [LINE_W-1:0] pat_c;
        logic [LINE_W-1:0] rnd;
        logic [ADDR_W-1:0] ra;
        pat_a = {$urandom, $urandom, $urandom, $urandom};
        pat_b = {$urandom, $urandom, $urandom, $urandom};
        pat_c = {$urandom, $urandom, $urandom, $urandom};

        repeat (3) @(negedge clk);
        check("reset_resp", LINE_W'(resp), '0);
        check("reset_rdata", rdata, '0);
        check("reset_err", LINE_W'(protocol_err), '0);
        check("reset_rd_count", LINE_W'(rd_count), '0);
        check("reset_wr_count", LINE_W'(wr_count), '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic write then read of the same line, low address bits ignored.
        do_op(1'b0, 1'b0, 16'h0040, 128'hDEADBEEF_0123_4567_89AB_CDEF_0011_2233, 0);
        idle(1);
        check("resp_width", LINE_W'(resp), '0);
        check_counts();
        do_op(1'b1, 1'b0, 16'h004F, '0, 0);
        idle(1);
        check_counts();
        check("err_clean", LINE_W'(protocol_err), '0);

        // Aliasing write followed by a back-to-back read held across resp.
        do_op(1'b0, 1'b0, 16'h0400, pat_a, 0);
        do_op(1'b1, 1'b0, 16'h0000, '0, 0);
        idle(1);
        check("rdata_hold", rdata, pat_a);
        check("err_after_alias", LINE_W'(protocol_err), '0);

        // Read and write together: serviced as a write, flagged.
        do_op(1'b0, 1'b1, 16'h0080, pat_b, 0);
        idle(1);
        check("err_both", LINE_W'(protocol_err), 128'd1);
        do_op(1'b1, 1'b0, 16'h0080, '0, 0);
        idle(1);
        check("rdata_after_write", rdata, pat_b);
        check_counts();

        // Request dropped mid-BUSY.
        do_reset();
        @(negedge clk);
        check("err_cleared", LINE_W'(protocol_err), '0);
        do_op(1'b1, 1'b0, 16'h0040, '0, 1);
        idle(1);
        check("err_drop", LINE_W'(protocol_err), LINE_W'(exp_err));

        // Address moved mid-BUSY: latched address is used.
        do_reset();
        @(negedge clk);
        do_op(1'b1, 1'b0, 16'h0080, '0, 2);
        idle(1);
        check("err_addr", LINE_W'(protocol_err), LINE_W'(exp_err));

        // Reset in the middle of a write: no resp, array untouched.
        do_reset();
        @(negedge clk);
        do_op(1'b0, 1'b0, 16'h00C0, pat_c, 0);
        idle(2);
        write   = 1'b1;
        address = 16'h00C0;
        wdata   = ~pat_c;
        repeat (3) @(negedge clk);
        do_reset();
        repeat (12) @(negedge clk);
        check_counts();
        do_op(1'b1, 1'b0, 16'h00C0, '0, 0);
        idle(1);
        check("rdata_survives_reset", rdata, pat_c);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            ra = 16'($urandom);
            if ($urandom_range(0, 1) == 1 && model_mem.exists(int'(ra[4+IDX_W-1:4]))) begin
                do_op(1'b1, 1'b0, ra, '0, 0);
            end else begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                do_op(1'b0, 1'b0, ra, rnd, 0);
            end
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(1);
        check_counts();
        check("err_random", LINE_W'(protocol_err), '0);

        // Read counter wrap.
        force dut.rd_count = 16'hFFFE;
        #1;
        release dut.rd_count;
        exp_rd = 16'hFFFE;
        do_op(1'b1, 1'b0, 16'h00C0, '0, 0);
        do_op(1'b1, 1'b0, 16'h0080, '0, 0);
        idle(1);
        check("rd_count_wrap", LINE_W'(rd_count), LINE_W'(exp_rd));
        check("rd_count_zero", LINE_W'(rd_count), '0);

        idle(4);
        check("queue_drained", LINE_W'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
